// File: rtl/rs_issue_queue_if.sv
// Dispatch / CDB / issue bundle between the decode side and the reservation station.
// master: dispatch unit plus CDB sources (drives requests, sees full and ex_*).
// slave : the reservation station itself (drives full and the registered ex_* issue fields).
interface rs_issue_queue_if #(
    parameter int TAG_W    = 4,
    parameter int OPENUM_W = 6
);
    logic                rollback;
    logic                dis_valid;
    logic [OPENUM_W-1:0] dis_openum;
    logic [31:0]         dis_v1;
    logic                dis_q1_busy;
    logic [TAG_W-1:0]    dis_q1;
    logic [31:0]         dis_v2;
    logic                dis_q2_busy;
    logic [TAG_W-1:0]    dis_q2;
    logic [31:0]         dis_imm;
    logic [31:0]         dis_pc;
    logic [TAG_W-1:0]    dis_rob_id;
    logic                alu_cdb_valid;
    logic [TAG_W-1:0]    alu_cdb_tag;
    logic [31:0]         alu_cdb_data;
    logic                lsb_cdb_valid;
    logic [TAG_W-1:0]    lsb_cdb_tag;
    logic [31:0]         lsb_cdb_data;
    logic                full;
    logic [OPENUM_W-1:0] ex_openum;
    logic [31:0]         ex_v1;
    logic [31:0]         ex_v2;
    logic [31:0]         ex_imm;
    logic [31:0]         ex_pc;
    logic [TAG_W-1:0]    ex_rob_id;

    modport master (
        output rollback, dis_valid, dis_openum, dis_v1, dis_q1_busy, dis_q1,
               dis_v2, dis_q2_busy, dis_q2, dis_imm, dis_pc, dis_rob_id,
               alu_cdb_valid, alu_cdb_tag, alu_cdb_data,
               lsb_cdb_valid, lsb_cdb_tag, lsb_cdb_data,
        input  full, ex_openum, ex_v1, ex_v2, ex_imm, ex_pc, ex_rob_id
    );

    modport slave (
        input  rollback, dis_valid, dis_openum, dis_v1, dis_q1_busy, dis_q1,
               dis_v2, dis_q2_busy, dis_q2, dis_imm, dis_pc, dis_rob_id,
               alu_cdb_valid, alu_cdb_tag, alu_cdb_data,
               lsb_cdb_valid, lsb_cdb_tag, lsb_cdb_data,
        output full, ex_openum, ex_v1, ex_v2, ex_imm, ex_pc, ex_rob_id
    );
endinterface

// File: rtl/rs_issue_queue.sv
// Reservation station feeding the ALU execute stage: holds ops until both operands are ready, snoops ALU/LSB CDBs.
// Latency: ready op dispatched at edge t appears on ex_* after edge t+1; one issue per cycle, lowest index first.
// Backpressure: full is raised when every entry is busy; a dispatch while full is dropped (dispatch must hold it).
// Ports: clk, rst_n (async active-low), bus (slave side of rs_issue_queue_if: dispatch, two CDBs, rollback, full, ex_*).
module rs_issue_queue #(
    parameter int RS_SIZE  = 16,
    parameter int TAG_W    = 4,
    parameter int OPENUM_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    rs_issue_queue_if.slave bus
);
    localparam int IDX_W = $clog2(RS_SIZE);
    localparam logic [OPENUM_W-1:0] OPENUM_NOP = '0;

    typedef struct packed {
        logic                busy;
        logic [OPENUM_W-1:0] openum;
        logic [31:0]         v1;
        logic                q1_busy;
        logic [TAG_W-1:0]    q1;
        logic [31:0]         v2;
        logic                q2_busy;
        logic [TAG_W-1:0]    q2;
        logic [31:0]         imm;
        logic [31:0]         pc;
        logic [TAG_W-1:0]    rob_id;
    } ent_t;

    typedef struct packed {
        logic             vld;
        logic [TAG_W-1:0] tag;
        logic [31:0]      dat;
    } cdb_t;

    ent_t                r_ent [RS_SIZE];
    ent_t                w_nxt [RS_SIZE];
    ent_t                w_dis_ent;
    cdb_t                w_alu;
    cdb_t                w_lsb;
    logic                w_free_vld;
    logic [IDX_W-1:0]    w_free_idx;
    logic                w_sel_vld;
    logic [IDX_W-1:0]    w_sel_idx;
    logic [OPENUM_W-1:0] r_ex_openum;
    logic [31:0]         r_ex_v1;
    logic [31:0]         r_ex_v2;
    logic [31:0]         r_ex_imm;
    logic [31:0]         r_ex_pc;
    logic [TAG_W-1:0]    r_ex_rob_id;

    // Resolve one operand against both CDBs; returns {still_busy, value}.
    // ALU is checked first so it wins when both buses carry the same tag.
    function automatic logic [32:0] f_snoop(input logic q_busy, input logic [TAG_W-1:0] q,
                                            input logic [31:0] v, input cdb_t alu, input cdb_t lsb);
        if (q_busy && alu.vld && (alu.tag == q)) return {1'b0, alu.dat};
        if (q_busy && lsb.vld && (lsb.tag == q)) return {1'b0, lsb.dat};
        return {q_busy, v};
    endfunction

    assign w_alu = '{vld: bus.alu_cdb_valid, tag: bus.alu_cdb_tag, dat: bus.alu_cdb_data};
    assign w_lsb = '{vld: bus.lsb_cdb_valid, tag: bus.lsb_cdb_tag, dat: bus.lsb_cdb_data};

    // Free-slot and select searches look only at registered state, so a slot freed
    // by this cycle's issue is not reusable until next cycle.
    always_comb begin
        w_free_vld = 1'b0;
        w_free_idx = '0;
        w_sel_vld  = 1'b0;
        w_sel_idx  = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!r_ent[i].busy) begin
                w_free_vld = 1'b1;
                w_free_idx = IDX_W'(i);
            end
            if (r_ent[i].busy && !r_ent[i].q1_busy && !r_ent[i].q2_busy) begin
                w_sel_vld = 1'b1;
                w_sel_idx = IDX_W'(i);
            end
        end
    end

    // Incoming entry with same-cycle CDB bypass on both operands.
    always_comb begin
        w_dis_ent        = '0;
        w_dis_ent.busy   = 1'b1;
        w_dis_ent.openum = bus.dis_openum;
        w_dis_ent.q1     = bus.dis_q1;
        w_dis_ent.q2     = bus.dis_q2;
        w_dis_ent.imm    = bus.dis_imm;
        w_dis_ent.pc     = bus.dis_pc;
        w_dis_ent.rob_id = bus.dis_rob_id;
        {w_dis_ent.q1_busy, w_dis_ent.v1} = f_snoop(bus.dis_q1_busy, bus.dis_q1, bus.dis_v1, w_alu, w_lsb);
        {w_dis_ent.q2_busy, w_dis_ent.v2} = f_snoop(bus.dis_q2_busy, bus.dis_q2, bus.dis_v2, w_alu, w_lsb);
    end

    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            w_nxt[i] = r_ent[i];
            if (r_ent[i].busy) begin
                {w_nxt[i].q1_busy, w_nxt[i].v1} = f_snoop(r_ent[i].q1_busy, r_ent[i].q1, r_ent[i].v1, w_alu, w_lsb);
                {w_nxt[i].q2_busy, w_nxt[i].v2} = f_snoop(r_ent[i].q2_busy, r_ent[i].q2, r_ent[i].v2, w_alu, w_lsb);
            end
        end
        if (w_sel_vld)
            w_nxt[w_sel_idx].busy = 1'b0;
        // Selected and free indices can never collide: one is busy, the other is not.
        if (bus.dis_valid && w_free_vld)
            w_nxt[w_free_idx] = w_dis_ent;
        // Flush overrides any dispatch or issue in the same cycle.
        if (bus.rollback) begin
            for (int i = 0; i < RS_SIZE; i++)
                w_nxt[i].busy = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RS_SIZE; i++)
                r_ent[i] <= '0;
            r_ex_openum <= OPENUM_NOP;
            r_ex_v1     <= '0;
            r_ex_v2     <= '0;
            r_ex_imm    <= '0;
            r_ex_pc     <= '0;
            r_ex_rob_id <= '0;
        end else begin
            r_ent <= w_nxt;
            if (!bus.rollback && w_sel_vld) begin
                r_ex_openum <= r_ent[w_sel_idx].openum;
                r_ex_v1     <= r_ent[w_sel_idx].v1;
                r_ex_v2     <= r_ent[w_sel_idx].v2;
                r_ex_imm    <= r_ent[w_sel_idx].imm;
                r_ex_pc     <= r_ent[w_sel_idx].pc;
                r_ex_rob_id <= r_ent[w_sel_idx].rob_id;
            end else begin
                // Idle or flushed: only the opcode is forced, data fields hold.
                r_ex_openum <= OPENUM_NOP;
            end
        end
    end

    assign bus.full      = !w_free_vld;
    assign bus.ex_openum = r_ex_openum;
    assign bus.ex_v1     = r_ex_v1;
    assign bus.ex_v2     = r_ex_v2;
    assign bus.ex_imm    = r_ex_imm;
    assign bus.ex_pc     = r_ex_pc;
    assign bus.ex_rob_id = r_ex_rob_id;
endmodule
